// File: rtl/xm23_pkg.sv
// Shared encodings for the XM23 MAR/MDR memory controller.
// State codes, access/size codes and the wait-counter width helper.
package xm23_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_CAPT  = 2'd3;

    localparam logic ACC_RD  = 1'b0;
    localparam logic ACC_WR  = 1'b1;
    localparam logic SZ_WORD = 1'b0;
    localparam logic SZ_BYTE = 1'b1;

    function automatic int cnt_width(input int waits);
        return (waits > 0) ? $clog2(waits + 1) : 1;
    endfunction

endpackage

// File: rtl/xm23_lane_steer.sv
// Byte-lane steering: lo/hi address pair, write data/enables, read assembly.
// Purely combinational; the controller registers everything it produces.
module xm23_lane_steer
    import xm23_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr,
    input  logic              size,
    input  logic [15:0]       wdata,
    input  logic              rd_size,
    input  logic [7:0]        rdata_lo,
    input  logic [7:0]        rdata_hi,
    output logic [ADDR_W-1:0] addr_lo,
    output logic [ADDR_W-1:0] addr_hi,
    output logic [7:0]        wdata_lo,
    output logic [7:0]        wdata_hi,
    output logic              we_lo,
    output logic              we_hi,
    output logic [15:0]       rdata
);

    logic is_wr;
    logic is_word;

    assign is_wr   = (wr == ACC_WR);
    assign is_word = (size == SZ_WORD);

    // High lane wraps naturally at the top of the address space.
    assign addr_lo  = addr;
    assign addr_hi  = addr + ADDR_W'(1);
    assign we_lo    = is_wr;
    assign we_hi    = is_wr && is_word;
    assign wdata_lo = is_wr ? wdata[7:0] : 8'h00;
    assign wdata_hi = (is_wr && is_word) ? wdata[15:8] : 8'h00;
    assign rdata    = (rd_size == SZ_BYTE) ? {8'h00, rdata_lo}
                                           : {rdata_hi, rdata_lo};

endmodule

// File: rtl/xm23_mem_ctrl.sv
// MAR/MDR memory controller: CPU port plus read-only debug port onto split
// byte-lane RAM, with wait states, alignment faults and done/fault pulses.
module xm23_mem_ctrl
    import xm23_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int WAIT_STATES = 0,
    parameter int ALIGN_CHECK = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic              cpu_byte,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_wdata,
    output logic [15:0]       cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_fault,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [15:0]       dbg_rdata,
    output logic              dbg_done,
    output logic [ADDR_W-1:0] mem_addr_lo,
    output logic [ADDR_W-1:0] mem_addr_hi,
    output logic [7:0]        mem_wdata_lo,
    output logic [7:0]        mem_wdata_hi,
    output logic              mem_we_lo,
    output logic              mem_we_hi,
    input  logic [7:0]        mem_rdata_lo,
    input  logic [7:0]        mem_rdata_hi
);

    localparam int CW = cnt_width(WAIT_STATES);
    localparam logic [CW-1:0] CNT_INIT =
        (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic              own_dbg;
    logic              wr_q;
    logic              size_q;

    logic              idle;
    logic              misalign;
    logic              take_fault;
    logic              take_cpu;
    logic              take_dbg;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_wr;
    logic              sel_size;
    logic [ADDR_W-1:0] st_addr_lo;
    logic [ADDR_W-1:0] st_addr_hi;
    logic [7:0]        st_wdata_lo;
    logic [7:0]        st_wdata_hi;
    logic              st_we_lo;
    logic              st_we_hi;
    logic [15:0]       st_rdata;

    // A pending done/fault pulse forces one idle turnaround cycle.
    assign idle = (state == ST_IDLE) && !cpu_done && !cpu_fault && !dbg_done;
    assign misalign = (ALIGN_CHECK != 0) && (cpu_byte == SZ_WORD) && cpu_addr[0];

    assign take_fault = idle && cpu_req && misalign;
    assign take_cpu   = idle && cpu_req && !misalign;
    assign take_dbg   = idle && !cpu_req && dbg_req;

    assign sel_addr = take_cpu ? cpu_addr : dbg_addr;
    assign sel_wr   = take_cpu ? cpu_wr : ACC_RD;
    assign sel_size = take_cpu ? cpu_byte : SZ_WORD;

    xm23_lane_steer #(
        .ADDR_W (ADDR_W)
    ) u_steer (
        .addr     (sel_addr),
        .wr       (sel_wr),
        .size     (sel_size),
        .wdata    (cpu_wdata),
        .rd_size  (size_q),
        .rdata_lo (mem_rdata_lo),
        .rdata_hi (mem_rdata_hi),
        .addr_lo  (st_addr_lo),
        .addr_hi  (st_addr_hi),
        .wdata_lo (st_wdata_lo),
        .wdata_hi (st_wdata_hi),
        .we_lo    (st_we_lo),
        .we_hi    (st_we_hi),
        .rdata    (st_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            own_dbg      <= 1'b0;
            wr_q         <= ACC_RD;
            size_q       <= SZ_WORD;
            cpu_rdata    <= '0;
            cpu_done     <= 1'b0;
            cpu_fault    <= 1'b0;
            dbg_rdata    <= '0;
            dbg_done     <= 1'b0;
            mem_addr_lo  <= '0;
            mem_addr_hi  <= '0;
            mem_wdata_lo <= '0;
            mem_wdata_hi <= '0;
            mem_we_lo    <= 1'b0;
            mem_we_hi    <= 1'b0;
        end else begin
            cpu_done  <= 1'b0;
            cpu_fault <= 1'b0;
            dbg_done  <= 1'b0;
            mem_we_lo <= 1'b0;
            mem_we_hi <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (take_fault) begin
                        cpu_fault <= 1'b1;
                    end else if (take_cpu || take_dbg) begin
                        state        <= ST_ISSUE;
                        own_dbg      <= take_dbg;
                        wr_q         <= sel_wr;
                        size_q       <= sel_size;
                        mem_addr_lo  <= st_addr_lo;
                        mem_addr_hi  <= st_addr_hi;
                        mem_wdata_lo <= st_wdata_lo;
                        mem_wdata_hi <= st_wdata_hi;
                        mem_we_lo    <= st_we_lo;
                        mem_we_hi    <= st_we_hi;
                    end
                end
                ST_ISSUE: begin
                    cnt   <= CNT_INIT;
                    state <= (WAIT_STATES > 0) ? ST_WAIT : ST_CAPT;
                end
                ST_WAIT: begin
                    if (cnt == '0) state <= ST_CAPT;
                    else cnt <= cnt - CW'(1);
                end
                ST_CAPT: begin
                    state <= ST_IDLE;
                    if (own_dbg) begin
                        dbg_rdata <= st_rdata;
                        dbg_done  <= 1'b1;
                    end else begin
                        // Writes leave the MDR-in register untouched.
                        if (wr_q == ACC_RD) cpu_rdata <= st_rdata;
                        cpu_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xm23_mem_ctrl.sv
// Bench for xm23_mem_ctrl: two instances (no wait/aligned, 3 waits/unaligned)
// on byte-lane RAM models, checked against a byte-array reference model.
module tb_xm23_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cpu_req0, cpu_req1, cpu_wr, cpu_byte;
    logic [15:0] cpu_addr, cpu_wdata;
    logic        dbg_req0, dbg_req1;
    logic [15:0] dbg_addr;

    logic [15:0] cpu_rdata0, dbg_rdata0, addr_lo0, addr_hi0;
    logic        cpu_done0, cpu_fault0, dbg_done0, we_lo0, we_hi0;
    logic [7:0]  wd_lo0, wd_hi0, rd_lo0, rd_hi0;
    logic [15:0] cpu_rdata1, dbg_rdata1, addr_lo1, addr_hi1;
    logic        cpu_done1, cpu_fault1, dbg_done1, we_lo1, we_hi1;
    logic [7:0]  wd_lo1, wd_hi1, rd_lo1, rd_hi1;

    bit [7:0] ram0 [65536];
    bit [7:0] ram1 [65536];
    bit [7:0] mdl0 [65536];
    bit [7:0] mdl1 [65536];

    int n_chk = 0;
    int n_pass = 0;
    logic [15:0] last0, last1;

    xm23_mem_ctrl #(.ADDR_W(16), .WAIT_STATES(0), .ALIGN_CHECK(1)) u_d0 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req0), .cpu_wr(cpu_wr), .cpu_byte(cpu_byte),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata0), .cpu_done(cpu_done0), .cpu_fault(cpu_fault0),
        .dbg_req(dbg_req0), .dbg_addr(dbg_addr),
        .dbg_rdata(dbg_rdata0), .dbg_done(dbg_done0),
        .mem_addr_lo(addr_lo0), .mem_addr_hi(addr_hi0),
        .mem_wdata_lo(wd_lo0), .mem_wdata_hi(wd_hi0),
        .mem_we_lo(we_lo0), .mem_we_hi(we_hi0),
        .mem_rdata_lo(rd_lo0), .mem_rdata_hi(rd_hi0)
    );

    xm23_mem_ctrl #(.ADDR_W(16), .WAIT_STATES(3), .ALIGN_CHECK(0)) u_d1 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req1), .cpu_wr(cpu_wr), .cpu_byte(cpu_byte),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata1), .cpu_done(cpu_done1), .cpu_fault(cpu_fault1),
        .dbg_req(dbg_req1), .dbg_addr(dbg_addr),
        .dbg_rdata(dbg_rdata1), .dbg_done(dbg_done1),
        .mem_addr_lo(addr_lo1), .mem_addr_hi(addr_hi1),
        .mem_wdata_lo(wd_lo1), .mem_wdata_hi(wd_hi1),
        .mem_we_lo(we_lo1), .mem_we_hi(we_hi1),
        .mem_rdata_lo(rd_lo1), .mem_rdata_hi(rd_hi1)
    );

    always @(posedge clk) begin
        if (we_lo0) ram0[addr_lo0] <= wd_lo0;
        if (we_hi0) ram0[addr_hi0] <= wd_hi0;
        rd_lo0 <= ram0[addr_lo0];
        rd_hi0 <= ram0[addr_hi0];
    end

    always @(posedge clk) begin
        if (we_lo1) ram1[addr_lo1] <= wd_lo1;
        if (we_hi1) ram1[addr_hi1] <= wd_hi1;
        rd_lo1 <= ram1[addr_lo1];
        rd_hi1 <= ram1[addr_hi1];
    end

    task automatic chk(input string name, input logic [95:0] act,
                       input logic [95:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    function automatic logic [15:0] mrd(input int k, input logic [15:0] a,
                                        input logic b);
        logic [15:0] a1;
        logic [7:0]  lo, hi;
        a1 = a + 16'd1;
        lo = (k == 0) ? mdl0[a] : mdl1[a];
        hi = (k == 0) ? mdl0[a1] : mdl1[a1];
        return b ? {8'h00, lo} : {hi, lo};
    endfunction

    task automatic mwr(input int k, input logic [15:0] a, input logic b,
                       input logic [15:0] d);
        logic [15:0] a1;
        a1 = a + 16'd1;
        if (k == 0) begin
            mdl0[a] = d[7:0];
            if (!b) mdl0[a1] = d[15:8];
        end else begin
            mdl1[a] = d[7:0];
            if (!b) mdl1[a1] = d[15:8];
        end
    endtask

    // One CPU access presented to both instances at once.
    task automatic access(input logic wr, input logic b, input logic [15:0] a,
                          input logic [15:0] d, input logic [15:0] exp0,
                          input bit has_exp0, input string tag);
        logic f0;
        logic [15:0] e0, e1;
        int l0, l1, dn0, dn1, fl0, fl1, wl0, wh0, wl1, wh1;
        bit r0, r1, bad0, bad1;
        f0 = !b && a[0];
        e0 = (wr || f0) ? last0 : (has_exp0 ? exp0 : mrd(0, a, b));
        e1 = wr ? last1 : mrd(1, a, b);
        l0 = -1; l1 = -1;
        dn0 = 0; dn1 = 0; fl0 = 0; fl1 = 0;
        wl0 = 0; wh0 = 0; wl1 = 0; wh1 = 0;
        r0 = 0; r1 = 0; bad0 = 0; bad1 = 0;
        @(negedge clk);
        cpu_wr = wr; cpu_byte = b; cpu_addr = a; cpu_wdata = d;
        cpu_req0 = 1'b1; cpu_req1 = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!r0 && !f0 && (addr_lo0 !== a || addr_hi0 !== a + 16'd1)) bad0 = 1;
            if (!r1 && (addr_lo1 !== a || addr_hi1 !== a + 16'd1)) bad1 = 1;
            wl0 += int'(we_lo0); wh0 += int'(we_hi0);
            wl1 += int'(we_lo1); wh1 += int'(we_hi1);
            dn0 += int'(cpu_done0); fl0 += int'(cpu_fault0);
            dn1 += int'(cpu_done1); fl1 += int'(cpu_fault1);
            if ((cpu_done0 || cpu_fault0) && !r0) begin
                r0 = 1; l0 = c; cpu_req0 = 1'b0;
            end
            if ((cpu_done1 || cpu_fault1) && !r1) begin
                r1 = 1; l1 = c; cpu_req1 = 1'b0;
            end
            if (r0 && r1 && c >= l0 + 3 && c >= l1 + 3) break;
        end
        cpu_req0 = 1'b0; cpu_req1 = 1'b0;
        chk({tag, " resolved"}, {r0, r1}, 2'b11);
        chk({tag, " edges0"}, l0, f0 ? 0 : 2);
        chk({tag, " edges1"}, l1, 5);
        chk({tag, " done0"}, {dn0[3:0], fl0[3:0]}, f0 ? 8'h01 : 8'h10);
        chk({tag, " done1"}, {dn1[3:0], fl1[3:0]}, 8'h10);
        chk({tag, " we0"}, {wl0[3:0], wh0[3:0]},
            {4'(wr && !f0), 4'(wr && !b && !f0)});
        chk({tag, " we1"}, {wl1[3:0], wh1[3:0]}, {4'(wr), 4'(wr && !b)});
        chk({tag, " addr0"}, bad0, 0);
        chk({tag, " addr1"}, bad1, 0);
        chk({tag, " rdata0"}, cpu_rdata0, e0);
        chk({tag, " rdata1"}, cpu_rdata1, e1);
        last0 = e0; last1 = e1;
        if (wr && !f0) mwr(0, a, b, d);
        if (wr) mwr(1, a, b, d);
    endtask

    typedef struct {
        logic        wr;
        logic        b;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] e;
        bit          has;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int lc, ld, wes;
        logic [15:0] dexp, cexp;

        tbl[0] = '{1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 16'h0011, 16'h775A, 16'h0000, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h5AEF, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 16'h0013, 16'h0000, 16'h0000, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 16'hFFFF, 16'h1234, 16'h0000, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0000, 1'b1};
        tbl[8] = '{1'b0, 1'b1, 16'h0011, 16'h0000, 16'h005A, 1'b1};
        tbl[9] = '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'h00EF, 1'b1};

        rst_n = 1'b0;
        cpu_req0 = 0; cpu_req1 = 0; cpu_wr = 0; cpu_byte = 0;
        cpu_addr = 0; cpu_wdata = 0;
        dbg_req0 = 0; dbg_req1 = 0; dbg_addr = 0;
        last0 = 0; last1 = 0;
        repeat (3) @(negedge clk);
        chk("reset d0", {cpu_rdata0, cpu_done0, cpu_fault0, dbg_rdata0,
            dbg_done0, addr_lo0, addr_hi0, wd_lo0, wd_hi0, we_lo0, we_hi0}, 0);
        chk("reset d1", {cpu_rdata1, cpu_done1, cpu_fault1, dbg_rdata1,
            dbg_done1, addr_lo1, addr_hi1, wd_lo1, wd_hi1, we_lo1, we_hi1}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            access(tbl[i].wr, tbl[i].b, tbl[i].a, tbl[i].d, tbl[i].e,
                   tbl[i].has, $sformatf("vec%0d", i));

        // CPU and viewer request together: CPU wins, viewer after turnaround.
        cexp = mrd(0, 16'h0010, 1'b0);
        dexp = mrd(0, 16'h0011, 1'b0);
        lc = -1; ld = -1; wes = 0;
        @(negedge clk);
        cpu_wr = 1'b0; cpu_byte = 1'b0; cpu_addr = 16'h0010;
        dbg_addr = 16'h0011;
        cpu_req0 = 1'b1; dbg_req0 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            wes += int'(we_lo0 | we_hi0);
            if (cpu_done0 && lc < 0) begin lc = c; cpu_req0 = 1'b0; end
            if (dbg_done0 && ld < 0) begin ld = c; dbg_req0 = 1'b0; end
            if (lc >= 0 && ld >= 0) break;
        end
        cpu_req0 = 1'b0; dbg_req0 = 1'b0;
        chk("arb cpu edges", lc, 2);
        chk("arb dbg edges", ld, 6);
        chk("arb no we", wes, 0);
        chk("arb dbg rdata", dbg_rdata0, dexp);
        chk("arb cpu rdata", cpu_rdata0, cexp);
        last0 = cexp;
        repeat (2) @(negedge clk);

        // Reset in the issue cycle of a write abandons it.
        @(negedge clk);
        cpu_wr = 1'b1; cpu_byte = 1'b0; cpu_addr = 16'h0030;
        cpu_wdata = 16'hCAFE; cpu_req0 = 1'b1;
        @(posedge clk);
        #1;
        chk("rst issue we", {we_lo0, we_hi0}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("rst outputs", {cpu_rdata0, cpu_done0, cpu_fault0, dbg_rdata0,
            dbg_done0, addr_lo0, addr_hi0, wd_lo0, wd_hi0, we_lo0, we_hi0}, 0);
        cpu_req0 = 1'b0;
        last0 = 0; last1 = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        access(1'b0, 1'b0, 16'h0030, 16'h0000, 16'h0000, 1'b1, "post_rst");

        for (int i = 0; i < 40; i++) begin
            logic [15:0] a;
            a = 16'h0040 + 16'($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) a = 16'hFFFE + 16'($urandom_range(0, 1));
            access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                   16'($urandom), 16'h0000, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
